// File: rtl/wb_regfile.sv
// Write-back stage and integer register file: write-back mux, single write port,
// two bypassing read ports, one non-bypassing debug port and a retired-write counter.
module wb_regfile #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [1:0]        wb_ctrl,
    input  logic [ADDR_W-1:0] wb_dst,
    input  logic [DATA_W-1:0] mem_data,
    input  logic [DATA_W-1:0] alu_result,
    input  logic [ADDR_W-1:0] rs_addr,
    input  logic [ADDR_W-1:0] rt_addr,
    input  logic [ADDR_W-1:0] dbg_addr,
    output logic [DATA_W-1:0] rs_data,
    output logic [DATA_W-1:0] rt_data,
    output logic [DATA_W-1:0] dbg_data,
    output logic [DATA_W-1:0] wb_data,
    output logic              wb_we,
    output logic [CNT_W-1:0]  wr_count
);

    localparam int NREG = 1 << ADDR_W;

    logic [DATA_W-1:0] regs [NREG];

    assign wb_data = wb_ctrl[1] ? mem_data : alu_result;
    assign wb_we   = rst_n & wb_ctrl[0] & (wb_dst != '0);

    // wb_we already excludes register 0, so regs[0] stays zero after reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < NREG; i++) begin
                regs[i] <= '0;
            end
            wr_count <= '0;
        end else if (wb_we) begin
            regs[wb_dst] <= wb_data;
            wr_count     <= wr_count + 1'b1;
        end
    end

    // Reads are forced to zero during reset so stale contents never leak out.
    always_comb begin
        rs_data = '0;
        if (rst_n && rs_addr != '0) begin
            if (wb_we && rs_addr == wb_dst) begin
                rs_data = wb_data;
            end else begin
                rs_data = regs[rs_addr];
            end
        end
    end

    always_comb begin
        rt_data = '0;
        if (rst_n && rt_addr != '0) begin
            if (wb_we && rt_addr == wb_dst) begin
                rt_data = wb_data;
            end else begin
                rt_data = regs[rt_addr];
            end
        end
    end

    always_comb begin
        dbg_data = '0;
        if (rst_n && dbg_addr != '0) begin
            dbg_data = regs[dbg_addr];
        end
    end

endmodule
